lbus_burst_gen: RTL
===================

LBUS_BURST_GEN -- requirements
Module: lbus_burst_gen

Interface
REQ-001 Parameter TMO_CYCLES, default 64, meaning consecutive READY_N-high cycles in DATA before abort (range 2..255).
REQ-002 CLK  input  1  single clock; all state changes on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 REQ  input  1  burst request; sampled only in IDLE.
REQ-005 LEN  input  8  burst beat count; 1..255 literal, 0 = 256 beats.
REQ-006 ADDR_IN  input  32  burst start address (byte address, 32-bit beats).
REQ-007 READY_N  input  1  local-bus target ready, active-low; low = beat completes this cycle.
REQ-008 ACK  output  1  one-cycle pulse: request accepted.
REQ-009 BUSY  output  1  high from ACK cycle until return to IDLE.
REQ-010 ADS_N  output  1  address strobe, active-low.
REQ-011 BLAST  output  1  burst-last, active-low; drives downstream last-beat latch.
REQ-012 LADDR  output  32  current beat address.
REQ-013 BEAT  output  1  one-cycle pulse per completed beat.
REQ-014 DONE  output  1  one-cycle pulse at burst end (normal or aborted).
REQ-015 TIMEOUT  output  1  one-cycle pulse on wait-state abort.

Function
REQ-016 FSM states IDLE, ADDR, DATA, FIN; all outputs registered.
REQ-017 IDLE: REQ=1 -> latch ADDR_IN and LEN, ACK=1 and BUSY=1 on next cycle, go ADDR.
REQ-018 ADDR: exactly one cycle; ADS_N=0, LADDR=latched address; go DATA.
REQ-019 DATA: READY_N=0 -> BEAT=1 next cycle, remaining count -1, LADDR +4.
REQ-020 DATA: READY_N=1 -> wait; LADDR, count, BLAST unchanged.
REQ-021 BLAST=0 in every DATA cycle with remaining count = 1, including LEN=1 bursts from first DATA cycle; BLAST=1 otherwise.
REQ-022 Beat completing with remaining = 1 -> go FIN; FIN: DONE=1, BLAST=1, BUSY=0 next cycle, go IDLE.
REQ-023 REQ while not IDLE is ignored; no ACK, no queuing.
REQ-024 REQ held high continuously -> new burst starts in first IDLE cycle after FIN (one idle cycle minimum between bursts).
REQ-025 LADDR wraps modulo 2^32 (0xFFFFFFFC + 4 = 0x00000000), no flag.
REQ-026 LEN=0 -> exactly 256 beats; 9-bit internal count.

Reset
REQ-027 RST=1 forces IDLE immediately regardless of state, including mid-burst.
REQ-028 Reset values: ADS_N=1, BLAST=1, ACK=0, BUSY=0, BEAT=0, DONE=0, TIMEOUT=0, LADDR=0, count=0, wait counter=0.
REQ-029 Reset mid-burst produces no DONE or TIMEOUT pulse.

Configuration
REQ-030 Macro LBUS_WAIT_TIMEOUT_EN defined: wait counter clears on each beat; reaching TMO_CYCLES consecutive waits in DATA -> go FIN with TIMEOUT=1 and DONE=1 same cycle, BLAST=1.
REQ-031 Macro undefined: no wait counter; DATA waits indefinitely; TIMEOUT tied 0.

Verification
REQ-032 LEN=4, ADDR_IN=0x1000, READY_N=0 always -> ADS_N low 1 cycle, 4 BEAT pulses, LADDR 0x1000/04/08/0C, BLAST low on 4th beat only, DONE one cycle later.
REQ-033 LEN=1, READY_N high 3 cycles then low -> BLAST low for all 4 DATA cycles, single BEAT, DONE.
REQ-034 LEN=0, ADDR_IN=0xFFFFFF00 -> 256 BEAT pulses, LADDR wraps to 0x00000000 on beat 65, DONE.
REQ-035 With LBUS_WAIT_TIMEOUT_EN, TMO_CYCLES=64, LEN=8, READY_N high after beat 2 -> TIMEOUT and DONE pulse after 64 wait cycles, exactly 2 BEATs; without macro, burst stays in DATA.
REQ-036 RST pulsed during beat 3 of LEN=8 -> all outputs at reset values immediately, no DONE; following REQ accepted normally.
REQ-037 REQ held high across two bursts, REQ pulses during DATA -> exactly one ACK per burst, one idle cycle between bursts.

Source files
------------

// File: rtl/lbus_burst_gen_if.sv
// Local-bus burst generator signal bundle: request/length/address in, strobes and status out.
// master = burst generator, slave = requester/target side.
interface lbus_burst_gen_if;
  logic        req;
  logic [7:0]  len;
  logic [31:0] addr_in;
  logic        ready_n;
  logic        ack;
  logic        busy;
  logic        ads_n;
  logic        blast;
  logic [31:0] laddr;
  logic        beat;
  logic        done;
  logic        timeout;

  modport master (
    input  req, len, addr_in, ready_n,
    output ack, busy, ads_n, blast, laddr, beat, done, timeout
  );

  modport slave (
    output req, len, addr_in, ready_n,
    input  ack, busy, ads_n, blast, laddr, beat, done, timeout
  );
endinterface

// File: rtl/lbus_burst_gen.sv
// Local-bus burst generator: address phase, counted data beats with wait states, fully registered outputs.
// Optional wait-state abort enabled by defining LBUS_WAIT_TIMEOUT_EN.
module lbus_burst_gen #(
  parameter int unsigned TMO_CYCLES = 64
) (
  input logic              clk,
  input logic              rst,
  lbus_burst_gen_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_FIN} state_t;

  state_t      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        ack_d, busy_d, ads_n_d, blast_d, beat_d, done_d;
  logic [31:0] laddr_d;

  if (TMO_CYCLES < 2 || TMO_CYCLES > 255) begin : g_bad_tmo
    $error("lbus_burst_gen: TMO_CYCLES must be in 2..255");
  end

`ifdef LBUS_WAIT_TIMEOUT_EN
  logic [7:0] wcnt_q, wcnt_d;
  logic       abort_q, abort_d;
  logic       timeout_d;
`else
  assign bus.timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    busy_d  = bus.busy;
    ads_n_d = 1'b1;
    blast_d = bus.blast;
    laddr_d = bus.laddr;
    beat_d  = 1'b0;
    done_d  = 1'b0;
`ifdef LBUS_WAIT_TIMEOUT_EN
    wcnt_d    = wcnt_q;
    abort_d   = abort_q;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          state_d = S_ADDR;
          ack_d   = 1'b1;
          busy_d  = 1'b1;
          ads_n_d = 1'b0;
          laddr_d = bus.addr_in;
          // LEN=0 encodes 256 beats: the zero test supplies the 9th bit
          cnt_d   = {(bus.len == 8'd0), bus.len};
        end
      end
      S_ADDR: begin
        state_d = S_DATA;
        blast_d = (cnt_q != 9'd1);
`ifdef LBUS_WAIT_TIMEOUT_EN
        wcnt_d  = '0;
        abort_d = 1'b0;
`endif
      end
      S_DATA: begin
        if (!bus.ready_n) begin
          beat_d  = 1'b1;
          laddr_d = bus.laddr + 32'd4;
          cnt_d   = cnt_q - 9'd1;
`ifdef LBUS_WAIT_TIMEOUT_EN
          wcnt_d  = '0;
`endif
          if (cnt_q == 9'd1) begin
            state_d = S_FIN;
            blast_d = 1'b1;
          end else begin
            // BLAST is registered, so it must drop one beat early
            blast_d = (cnt_q != 9'd2);
          end
        end
`ifdef LBUS_WAIT_TIMEOUT_EN
        else if (wcnt_q == 8'(TMO_CYCLES - 1)) begin
          state_d = S_FIN;
          blast_d = 1'b1;
          abort_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
`endif
      end
      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        blast_d = 1'b1;
`ifdef LBUS_WAIT_TIMEOUT_EN
        timeout_d = abort_q;
        abort_d   = 1'b0;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bus.ack   <= 1'b0;
      bus.busy  <= 1'b0;
      bus.ads_n <= 1'b1;
      bus.blast <= 1'b1;
      bus.laddr <= '0;
      bus.beat  <= 1'b0;
      bus.done  <= 1'b0;
`ifdef LBUS_WAIT_TIMEOUT_EN
      wcnt_q      <= '0;
      abort_q     <= 1'b0;
      bus.timeout <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus.ack   <= ack_d;
      bus.busy  <= busy_d;
      bus.ads_n <= ads_n_d;
      bus.blast <= blast_d;
      bus.laddr <= laddr_d;
      bus.beat  <= beat_d;
      bus.done  <= done_d;
`ifdef LBUS_WAIT_TIMEOUT_EN
      wcnt_q      <= wcnt_d;
      abort_q     <= abort_d;
      bus.timeout <= timeout_d;
`endif
    end
  end

endmodule
